bus_uart_tx: RTL and testbench
==============================

// Module: bus_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the tiny-CPU toggle-handshake bus; a bus target beside memory (own run/done slot).
//  CPU stores bytes to DATA; block queues them in a FIFO and serialises 8N1 on txd. STATUS reports busy/full/empty/count.
//  Full FIFO stalls the bus (done withheld) so no byte is ever dropped.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; >=2
//  FIFO_DEPTH    8   byte entries; power of 2, 2..16
// PORTS
//  clk      in   1   single clock; all logic on posedge
//  reset    in   1   asynchronous, active-high
//  addr     in   16  byte address; addr[1] selects register: 0=DATA, 1=STATUS; other bits ignored
//  cmd      in   2   bus command: read=0, write=1, read_b=2, write_b=3
//  run      in   1   request toggle; pending request when run != done
//  wr_data  in   16  write data; only [7:0] used
//  rd_data  out  16  read data; valid when done toggles
//  done     out  1   completion toggle
//  txd      out  1   UART serial output, idle high
// BEHAVIOUR
//  Reset (async): done=0, rd_data=0, txd=1, FIFO empty, FSM IDLE, bit/baud counters 0. Pending run!=done after reset is served normally.
//  Bus: request sampled each posedge while run!=done; serviced -> done toggles on that edge (1-cycle latency, as memory). Inputs held stable by master until done toggles.
//   write/write_b DATA: FIFO not full -> push wr_data[7:0], toggle done. Full -> no push, done held; retried each cycle.
//   write/write_b STATUS: ignored, done toggles.
//   read/read_b DATA: rd_data=16'h0000. read/read_b STATUS: rd_data={8'h00, count[3:0], 1'b0, empty, full, busy}.
//   count = FIFO occupancy saturated to 4 bits; busy = FSM != IDLE.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: txd=1; FIFO non-empty -> pop into shift reg, go START (txd=0 from next edge).
//   START, each DATA bit, PARITY, STOP each last exactly CLKS_PER_BIT cycles, baud counter 0..CLKS_PER_BIT-1.
//   DATA: LSB first, 8 bits, bit index 0..7. STOP: txd=1; at end -> IDLE; IDLE may pop on next cycle (1 idle clk between frames).
//  FIFO: rd/wr pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when MSBs differ and low bits equal.
//  Simultaneous push & pop: allowed when not full; occupancy unchanged. Full + pop same cycle: push still stalls this cycle, succeeds next.
//  Empty + push: data poppable no earlier than next cycle (no bypass).
//  Reset mid-frame: frame aborted, txd=1 immediately, queued bytes discarded.
// CONFIGURATION
//  Macro BUS_UART_TX_PARITY_EN:
//   defined: PARITY state after bit 7 sends even parity (XOR of 8 data bits), frame 11 bits (8E1).
//   undefined: PARITY state and logic absent; frame 10 bits (8N1).
// STRUCTURE
//  Package bus_pkg: bus_cmd_t enum (BUS_CMD_READ=0, BUS_CMD_WRITE=1, BUS_CMD_READ_B=2, BUS_CMD_WRITE_B=3), register offsets UART_REG_DATA=0, UART_REG_STATUS=2, STATUS bit positions.
//  FSM state typedef uart_tx_state_t local to this module.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/count, async active-high reset.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=8)
//  1 Reset, read STATUS -> rd_data=16'h0004, done toggles 1 cycle after run toggle; txd=1 throughout.
//  2 Write DATA 16'h1241 -> txd: 0 | 1,0,0,0,0,0,1,0 | 1, each 4 clks; busy=1 during frame, STATUS 0x0004 after.
//  3 9 back-to-back writes 0x00..0x08 -> 8th push sets full (STATUS bit1, count=8); 9th done withheld until first pop, then toggles; 9 frames in order.
//  4 write_b STATUS + read DATA -> done toggles each, FIFO unchanged, DATA read returns 16'h0000.
//  5 Reset asserted mid-DATA of 0x55 with 3 queued -> txd=1 same cycle; STATUS after release 0x0004; no further frames.
//  6 BUS_UART_TX_PARITY_EN: write 0x41 -> parity bit 0; write 0x43 -> parity bit 1; frame 44 clks.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for tiny-CPU bus targets: command encoding, UART
// register offsets and UART STATUS register bit positions.
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_CMD_READ    = 2'd0,
        BUS_CMD_WRITE   = 2'd1,
        BUS_CMD_READ_B  = 2'd2,
        BUS_CMD_WRITE_B = 2'd3
    } bus_cmd_t;

    // Byte offsets; only addr[1] distinguishes the two registers.
    localparam logic [15:0] UART_REG_DATA   = 16'h0000;
    localparam logic [15:0] UART_REG_STATUS = 16'h0002;

    // STATUS = {8'h00, count[3:0], 1'b0, empty, full, busy}
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_EMPTY_BIT = 2;
    localparam int unsigned STATUS_COUNT_LSB = 4;

    function automatic logic is_write(input bus_cmd_t c);
        return (c == BUS_CMD_WRITE) || (c == BUS_CMD_WRITE_B);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers (wrap modulo 2*DEPTH).
// Push when full and pop when empty are ignored. Read data is the head
// entry; a byte pushed into an empty FIFO is visible one cycle later.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter on the toggle-handshake bus.
// DATA writes queue bytes; a full FIFO withholds done until space frees.
// Optional macro BUS_UART_TX_PARITY_EN adds an even-parity bit (8E1),
// otherwise frames are 8N1.
module bus_uart_tx
    import bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [1:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        txd
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef BUS_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    uart_tx_state_t    state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_idx, bit_n;
    logic [7:0]        shift, shift_n;
    logic              txd_n;
    logic              pop;
    logic              bit_end;

    logic [7:0]        fifo_rd;
    logic              full, empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [3:0]        count_sat;
    logic [15:0]       status_word;

    bus_cmd_t          bus_cmd;
    logic              pending, wr_req, is_data, is_status, push, stall;
    logic              unused_bits;

`ifdef BUS_UART_TX_PARITY_EN
    logic              parity, parity_n;
`endif

    assign unused_bits = ^{addr[15:2], addr[0], wr_data[15:8]};

    assign bus_cmd   = bus_cmd_t'(cmd);
    assign pending   = (run != done);
    assign is_data   = (addr[1] == UART_REG_DATA[1]);
    assign is_status = (addr[1] == UART_REG_STATUS[1]);
    assign wr_req    = pending && is_write(bus_cmd);
    assign stall     = wr_req && is_data && full;
    assign push      = wr_req && is_data && !full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data[7:0]),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // STATUS word assembly with occupancy saturated to four bits.
    always_comb begin
        count_sat   = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        status_word = '0;
        status_word[STATUS_COUNT_LSB +: 4] = count_sat;
        status_word[STATUS_EMPTY_BIT]      = empty;
        status_word[STATUS_FULL_BIT]       = full;
        status_word[STATUS_BUSY_BIT]       = (state != ST_IDLE);
    end

    // Bus target: complete each pending request in one cycle unless stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            rd_data <= '0;
        end else if (pending) begin
            if (!stall) done <= ~done;
            if (!is_write(bus_cmd)) rd_data <= is_status ? status_word : 16'h0000;
        end
    end

    // Transmit state, counters and registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
`ifdef BUS_UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
`ifdef BUS_UART_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

    // Next-state logic; txd is derived from the next state so the line
    // changes on the same edge the state does.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        txd_n   = 1'b1;
        bit_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));
`ifdef BUS_UART_TX_PARITY_EN
        parity_n = parity;
`endif

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rd;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = ST_START;
`ifdef BUS_UART_TX_PARITY_EN
                    parity_n = ^fifo_rd;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`ifdef BUS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = ST_STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        case (state_n)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = shift_n[0];
`ifdef BUS_UART_TX_PARITY_EN
            ST_PARITY: txd_n = parity_n;
`endif
            default:   txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: randomized DATA/STATUS traffic,
// a UART line decoder feeding a received-byte queue, compared against
// the queue of bytes the bus accepted.
module tb_bus_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 8;
`ifdef BUS_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [1:0]  cmd;
    logic        run;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;
    logic        txd;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    int         mon_cnt = 0;
    logic       mon_act = 1'b0;
    logic [7:0] mon_byte;
    logic       mon_center;

    bus_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .cmd     (cmd),
        .run     (run),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .done    (done),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Line decoder: samples on negedge, bit centre at phase C/2.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_act = 1'b0;
                mon_cnt = 0;
            end else begin
                if (!mon_act && txd === 1'b0) begin
                    mon_act  = 1'b1;
                    mon_cnt  = 0;
                    mon_byte = '0;
                end
                if (mon_act) begin
                    int bit_no;
                    int phase;
                    bit_no = mon_cnt / C;
                    phase  = mon_cnt % C;
                    if (phase == C / 2) begin
                        mon_center = txd;
                        if (bit_no == 0) begin
                            check("start_bit", {31'd0, txd}, 32'd0);
                        end else if (bit_no <= 8) begin
                            mon_byte[bit_no-1] = txd;
                        end else if (bit_no < NB - 1) begin
                            check("parity_bit", {31'd0, txd}, {31'd0, ^mon_byte});
                        end else begin
                            check("stop_bit", {31'd0, txd}, 32'd1);
                            rx_q.push_back(mon_byte);
                            mon_act = 1'b0;
                        end
                    end else if (phase == C - 1) begin
                        check("bit_stable", {31'd0, txd}, {31'd0, mon_center});
                    end
                    mon_cnt++;
                end
            end
        end
    end

    // One bus transaction; called and returns at posedge+1.
    task automatic bus_op(input logic [15:0] a, input logic [1:0] c, input logic [15:0] d,
                          output logic [15:0] r, output int lat);
        addr    = a;
        cmd     = c;
        wr_data = d;
        run     = ~run;
        lat     = 0;
        while (done !== run && lat < 500) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== run) check("bus_timeout", {31'd0, done}, {31'd0, run});
        r = rd_data;
    endtask

    task automatic write_byte(input logic [15:0] d, output int lat);
        logic [15:0] r;
        bus_op({$urandom_range(0, 16383), 2'b00} & 16'hFFFD, 2'($urandom_range(0, 1) * 2 + 1), d, r, lat);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic read_status(output logic [15:0] r, output int lat);
        bus_op(16'h0002, 2'd0, 16'h0000, r, lat);
    endtask

    task automatic drain_and_compare(input string tag);
        int guard;
        int n;
        logic [15:0] r;
        int lat;
        guard = 0;
        while (rx_q.size() < exp_q.size() && guard < 60 * (exp_q.size() + 2)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3 * C) @(posedge clk);
        #1;
        check({tag, "_frames"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
        read_status(r, lat);
        check({tag, "_idle_status"}, {16'd0, r}, 32'h0004);
        check({tag, "_idle_lat"}, lat, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        int lat;
        int guard;

        reset = 1'b1; run = 1'b0; addr = '0; cmd = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_data", {16'd0, rd_data}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset-state STATUS and one-cycle latency
        read_status(r, lat);
        check("init_status", {16'd0, r}, 32'h0004);
        check("init_lat", lat, 1);
        repeat (10) @(posedge clk);
        #1;
        check("idle_txd", {31'd0, txd}, 32'd1);

        // Single byte, busy while framing
        write_byte(16'h1241, lat);
        check("wr_lat", lat, 1);
        repeat (5) @(posedge clk);
        #1;
        read_status(r, lat);
        check("busy_status", {16'd0, r}, 32'h0005);
        drain_and_compare("single");

        // Parity-relevant bytes
        write_byte(16'h0041, lat);
        write_byte(16'h0043, lat);
        drain_and_compare("parity");

        // STATUS write ignored, DATA read returns zero
        bus_op(16'h0002, 2'd3, 16'h00AB, r, lat);
        check("wr_status_lat", lat, 1);
        bus_op(16'h0000, 2'd0, 16'h0000, r, lat);
        check("rd_data_zero", {16'd0, r}, 32'd0);
        check("rd_data_lat", lat, 1);
        drain_and_compare("ignored");

        // Randomized bursts (never more than 8 pushes from idle, so never stalls)
        for (int round = 0; round < 8; round++) begin
            int nw;
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                write_byte(16'($urandom), lat);
                check("rand_wr_lat", lat, 1);
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    logic [15:0] a;
                    int kind;
                    a = 16'($urandom);
                    kind = $urandom_range(0, 2);
                    if (kind == 0) begin
                        a[1] = 1'b0;
                        bus_op(a, 2'($urandom_range(0, 1) * 2), 16'($urandom), r, lat);
                        check("rand_rd_data", {16'd0, r}, 32'd0);
                    end else if (kind == 1) begin
                        a[1] = 1'b1;
                        bus_op(a, 2'($urandom_range(0, 1) * 2), 16'($urandom), r, lat);
                        check("rand_status_hi", {24'd0, r[15:8]}, 32'd0);
                        check("rand_status_full", {30'd0, r[3], r[1]}, 32'd0);
                        check("rand_status_empty", {31'd0, r[2]}, {31'd0, r[7:4] == 4'd0});
                    end else begin
                        a[1] = 1'b1;
                        bus_op(a, 2'($urandom_range(0, 1) * 2 + 1), 16'($urandom), r, lat);
                    end
                    check("rand_op_lat", lat, 1);
                end
            end
            drain_and_compare("random");
        end

        // Fill FIFO while a frame is in flight, then stall on the extra write
        write_byte(16'h00A5, lat);
        guard = 0;
        while (!mon_act && guard < 50) begin @(posedge clk); #1; guard++; end
        check("frame_started", {31'd0, mon_act}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(16'(i), lat);
            check("fill_lat", lat, 1);
        end
        read_status(r, lat);
        check("full_status", {16'd0, r}, 32'h0083);
        write_byte(16'h005A, lat);
        check("stall_lat", {31'd0, (lat > 1) && (lat < 60)}, 32'd1);
        read_status(r, lat);
        check("refill_status", {16'd0, r}, 32'h0083);
        drain_and_compare("full");

        // Reset in the middle of a frame with bytes still queued
        write_byte(16'h0055, lat);
        write_byte(16'h0011, lat);
        write_byte(16'h0022, lat);
        write_byte(16'h0033, lat);
        guard = 0;
        while (!(mon_act && mon_cnt >= 3 * C) && guard < 100) begin @(posedge clk); #1; guard++; end
        check("mid_frame_reached", {31'd0, mon_act}, 32'd1);
        #2;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("abort_txd", {31'd0, txd}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        @(posedge clk);
        #1;
        read_status(r, lat);
        check("post_reset_status", {16'd0, r}, 32'h0004);
        repeat (200) @(posedge clk);
        #1;
        check("post_reset_frames", rx_q.size(), 0);
        check("post_reset_txd", {31'd0, txd}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
